apple_rr_sched: RTL and testbench
=================================

// Module: apple_rr_sched
// PURPOSE
//   Round-robin scheduler sharing one apple AND-register unit among NREQ requesters.
//   Each requester holds req with operand bits a/b until acked. The scheduler drives
//   apple_a/apple_b, waits the unit's 1-cycle register latency, samples apple_q, then
//   returns the result with the requester id. Sits between requester logic and the
//   single apple instance.
// PARAMETERS
//   NREQ  4  number of requesters, 2..16
//   IDW   $clog2(NREQ)  localparam, width of rsp_id
// PORTS
//   clk        in   1     clock; everything samples on posedge
//   rst        in   1     synchronous, active-high reset
//   req        in   NREQ  per-requester request; held until matching ack
//   req_a      in   NREQ  per-requester operand a; stable while req high
//   req_b      in   NREQ  per-requester operand b; stable while req high
//   ack        out  NREQ  one-hot, 1-cycle pulse: request consumed
//   rsp_valid  out  1     1-cycle pulse: rsp_id/rsp_q valid, coincident with ack
//   rsp_id     out  IDW   index of the served requester
//   rsp_q      out  1     result captured from apple_q
//   apple_a    out  1     operand to apple.a, registered
//   apple_b    out  1     operand to apple.b, registered
//   apple_q    in   1     apple.q; valid the cycle after apple_a/b have been applied
//   err        out  1     sticky self-check flag; only with APPLE_SCHED_CHECK_EN
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, ptr=0, and every output=0: ack, rsp_valid,
//     rsp_id, rsp_q, apple_a, apple_b, err. apple has no reset: apple_q is ignored
//     until a CAPTURE state follows an ISSUE. Reset mid-operation aborts the operation;
//     no ack is issued, and the requester stays pending and is re-arbitrated afterwards.
//   FSM, one transition per clk:
//     IDLE    : eligible = req & ~ack. If eligible!=0: pick winner by round robin,
//               latch id, apple_a<=req_a[id], apple_b<=req_b[id], go ISSUE.
//               Otherwise stay in IDLE.
//     ISSUE   : apple registers a&b on this edge. Go CAPTURE.
//     CAPTURE : apple_q valid. rsp_q<=apple_q, rsp_id<=id, rsp_valid<=1, ack[id]<=1,
//               ptr<=id+1 (wraps NREQ-1 -> 0). Go IDLE.
//   ack and rsp_valid are high exactly one cycle: the first IDLE cycle after CAPTURE.
//   Masking with ~ack in that cycle prevents re-granting a requester that is still
//     dropping req. A requester that holds req past the ack cycle is a new request.
//   Latency: req high in IDLE at cycle 0 -> ack and rsp_valid high at cycle 3.
//   Throughput: one operation per 3 cycles.
//   Round robin: search starts at ptr and increments mod NREQ; the first eligible wins.
//     After reset, requester 0 has highest priority.
//   Simultaneous requests: one winner per IDLE cycle; losers stay pending, never dropped.
//   req changes while granted are ignored: operands are latched at grant.
//   apple_a/apple_b hold their values between operations (no return to 0).
// CONFIGURATION
//   APPLE_SCHED_CHECK_EN defined:
//     - a&b is latched at grant.
//     - In CAPTURE, if apple_q != latched a&b: err<=1, which stays set until rst.
//     - A simulation $error reports id, received value and expected value.
//   APPLE_SCHED_CHECK_EN undefined:
//     - err tied to 0; no compare logic; ports unchanged.
// STRUCTURE
//   Package apple_sched_pkg: typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t.
//   Sub-module apple_rr_arb: combinational rotating-priority picker.
//     Inputs:  eligible[NREQ], ptr[IDW]
//     Outputs: gnt_valid, gnt_id[IDW]
//   Top level: FSM, operand/result registers, ptr, check logic.
// TESTING (bench: apple_rr_sched + apple instance, clk period 10)
//   1 Reset: rst=1 for 2 clk with all req=1 -> ack=0, rsp_valid=0, apple_a=apple_b=0,
//     err=0. After release, first ack is ack[0] at cycle 3.
//   2 Single requester, full truth table: req[2]=1 with (a,b)=00,01,10,11, dropping req
//     on each ack -> rsp_id=2, rsp_q=0,0,0,1, each 3 cycles after req.
//   3 Fairness: req=4'b1111 held continuously, NREQ=4 -> ack order 0,1,2,3,0,1;
//     rsp_valid every 3 cycles. Requester 1 is not starved by 0.
//   4 Ack masking: req[1] stays high 1 cycle past ack with other req=0 -> no immediate
//     re-grant in the ack cycle; re-grant occurs in the following IDLE cycle.
//   5 Reset mid-operation: assert rst during CAPTURE for req[3] -> no ack[3]; after
//     release, req[3] is still pending -> ack[3] 3 cycles later with the correct rsp_q.
//   6 CHECK_EN only: force apple_q=1 for a=1,b=0 -> err=1 the cycle after CAPTURE and
//     remains 1 until rst.

Source files
------------

// File: rtl/apple_sched_pkg.sv
// Shared types and helpers for the apple round-robin scheduler.
// Optional self-check is controlled by the APPLE_SCHED_CHECK_EN macro (see apple_rr_sched.sv).
package apple_sched_pkg;

  // Scheduler phases: arbitrate, let apple register the operands, sample its result.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Increment with wrap at n (n-1 -> 0); used for the round-robin pointer.
  function automatic logic [31:0] wrap_inc(input logic [31:0] v, input logic [31:0] n);
    return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
  endfunction

endpackage

// File: rtl/apple_rr_sched_if.sv
// Bundle between the requesters/apple unit (master side) and the scheduler (slave side).
//
// Handshake: requester i raises req[i] with req_a[i]/req_b[i] and holds all three
// stable until it sees ack[i]. ack[i] is a one-cycle pulse that always coincides
// with rsp_valid; in that cycle rsp_id==i and rsp_q carries apple's a&b result.
// A requester still showing req[i] in the cycle after its ack is making a new
// request. apple_a/apple_b are presented to apple and apple_q is its registered
// output, valid one clock after the operands were applied.
interface apple_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_a;
  logic [NREQ-1:0] req_b;
  logic [NREQ-1:0] ack;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic            rsp_q;
  logic            apple_a;
  logic            apple_b;
  logic            apple_q;
  logic            err;

  // Environment side: requesters plus the apple unit.
  modport master (
    output req, req_a, req_b, apple_q,
    input  ack, rsp_valid, rsp_id, rsp_q, apple_a, apple_b, err
  );

  // Scheduler side.
  modport slave (
    input  req, req_a, req_b, apple_q,
    output ack, rsp_valid, rsp_id, rsp_q, apple_a, apple_b, err
  );

endinterface

// File: rtl/apple_rr_arb.sv
// Combinational rotating-priority picker: searches upward from ptr (mod NREQ)
// and grants the first eligible requester.
module apple_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  ptr,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id
);

  int             idx;
  logic [IDW-1:0] cidx;

  // Walk the requesters starting at ptr; the first eligible one wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    cidx      = '0;
    for (int s = 0; s < NREQ; s++) begin
      idx = int'(ptr) + s;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      cidx = IDW'(idx);
      if (!gnt_valid && eligible[cidx]) begin
        gnt_valid = 1'b1;
        gnt_id    = cidx;
      end
    end
  end

endmodule

// File: rtl/apple_rr_sched.sv
// Round-robin scheduler sharing one apple AND-register unit among NREQ requesters.
// Each operation: grant in IDLE, apple registers a&b during ISSUE, result sampled
// in CAPTURE, ack/rsp_valid pulse in the following IDLE cycle (3 cycles per op).
// Optional: define APPLE_SCHED_CHECK_EN to compare apple_q against the a&b latched
// at grant and raise a sticky err; otherwise err is tied low.
module apple_rr_sched
  import apple_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  apple_rr_sched_if.slave  bus,
  output state_t           dbg_state
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ACK_ONE = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state_q;
  state_t          state_d;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_q;
  logic [NREQ-1:0] ack_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic            rsp_q_q;
  logic            apple_a_q;
  logic            apple_b_q;

  logic [NREQ-1:0] eligible;
  logic            gnt_valid;
  logic [IDW-1:0]  gnt_id;
  logic            grant;

  // A requester being acked this cycle may still show req while it drops it,
  // so it is excluded from this cycle's arbitration.
  assign eligible = bus.req & ~ack_q;
  assign grant    = (state_q == IDLE) && gnt_valid;

  apple_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Next-state logic: IDLE waits for a winner, then a fixed ISSUE -> CAPTURE run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight without acking it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch at grant, result capture and ack/response pulse generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      id_q        <= '0;
      ack_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q_q     <= 1'b0;
      apple_a_q   <= 1'b0;
      apple_b_q   <= 1'b0;
    end else begin
      ack_q       <= '0;
      rsp_valid_q <= 1'b0;
      if (grant) begin
        id_q      <= gnt_id;
        apple_a_q <= bus.req_a[gnt_id];
        apple_b_q <= bus.req_b[gnt_id];
      end
      if (state_q == CAPTURE) begin
        rsp_q_q     <= bus.apple_q;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
        ack_q       <= ACK_ONE << id_q;
        ptr_q       <= IDW'(wrap_inc(32'(id_q), 32'(NREQ)));
      end
    end
  end

`ifdef APPLE_SCHED_CHECK_EN
  logic exp_and_q;
  logic err_q;

  // Remember the expected a&b at grant; flag (sticky until reset) any apple_q disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_and_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (grant) begin
        exp_and_q <= bus.req_a[gnt_id] & bus.req_b[gnt_id];
      end
      if ((state_q == CAPTURE) && (bus.apple_q != exp_and_q)) begin
        err_q <= 1'b1;
        $error("apple_rr_sched: id %0d apple_q=%0b expected %0b", id_q, bus.apple_q, exp_and_q);
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.ack       = ack_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_q     = rsp_q_q;
  assign bus.apple_a   = apple_a_q;
  assign bus.apple_b   = apple_b_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_apple_rr_sched.sv
// Bench for apple_rr_sched with a behavioural apple unit and a transaction-level
// reference: each grant is scheduled to complete two edges later, and the next
// arbitration is allowed one edge after that.
module tb_apple_rr_sched;
  import apple_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);
  localparam int VW   = NREQ + IDW + 5;

  logic            clk;
  logic            rst;
  state_t          dbg_state;
  logic [NREQ-1:0] req_d;
  logic [NREQ-1:0] a_d;
  logic [NREQ-1:0] b_d;
  logic            apple_reg;
  logic            force_en;
  logic            force_val;

  int errors = 0;
  int checks = 0;

  apple_rr_sched_if #(.NREQ(NREQ)) bus ();

  assign bus.req   = req_d;
  assign bus.req_a = a_d;
  assign bus.req_b = b_d;

  // Behavioural apple: one register stage computing a&b, optionally overridden.
  always @(posedge clk) apple_reg <= bus.apple_a & bus.apple_b;
  assign bus.apple_q = force_en ? force_val : apple_reg;

  apple_rr_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int              edge_n = 0;
  int              free_edge = 0;
  int              m_ptr = 0;
  int              win;
  int              model_acks = 0;
  int              dut_acks = 0;
  logic [IDW-1:0]  wi;
  logic [IDW-1:0]  ci;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] m_ack;
  logic            m_rv, m_q, m_a, m_b, m_err;
  logic [IDW-1:0]  m_id;
  logic [IDW:0]    exp_q[$];
  int              due_q[$];
  logic [IDW:0]    ent;
  logic            seen_q;

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      m_ack = '0; m_rv = 1'b0; m_id = '0; m_q = 1'b0;
      m_a = 1'b0; m_b = 1'b0; m_err = 1'b0;
      m_ptr = 0;
      free_edge = edge_n + 1;
    end else begin
      if (edge_n >= free_edge) begin
        elig = req_d & ~m_ack;
        win = -1;
        for (int s = 0; s < NREQ; s++) begin
          ci = IDW'((m_ptr + s) % NREQ);
          if (win < 0 && elig[ci]) win = (m_ptr + s) % NREQ;
        end
        if (win >= 0) begin
          wi = IDW'(win);
          m_a = a_d[wi];
          m_b = b_d[wi];
          exp_q.push_back({wi, a_d[wi] & b_d[wi]});
          due_q.push_back(edge_n + 2);
          free_edge = edge_n + 3;
          m_ptr = (win + 1) % NREQ;
        end
      end
      m_ack = '0;
      m_rv = 1'b0;
      if (due_q.size() != 0 && due_q[0] == edge_n) begin
        ent = exp_q.pop_front();
        due_q.delete(0);
        seen_q = force_en ? force_val : ent[0];
        m_ack[ent[IDW:1]] = 1'b1;
        m_rv = 1'b1;
        m_id = ent[IDW:1];
        m_q = seen_q;
        model_acks = model_acks + 1;
`ifdef APPLE_SCHED_CHECK_EN
        if (seen_q !== ent[0]) m_err = 1'b1;
`endif
      end
    end
  end

  logic [VW-1:0] dut_vec;
  logic [VW-1:0] exp_vec;
  assign dut_vec = {bus.ack, bus.rsp_valid, bus.rsp_id, bus.rsp_q, bus.apple_a, bus.apple_b, bus.err};
  assign exp_vec = {m_ack, m_rv, m_id, m_q, m_a, m_b, m_err};

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    rst = 1'b1; req_d = '1; a_d = '1; b_d = '1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %b expected %b", dut_vec, {VW{1'b0}});
      end
    end
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_model: got %b expected %b", dut_vec, exp_vec);
      end
    end while (bus.ack == '0 && n < 10);
    checks++;
    if (bus.ack !== 4'b0001 || n != 3) begin
      errors++;
      $display("FAIL reset_first_ack: got ack=%b at cycle %0d expected ack=0001 at cycle 3", bus.ack, n);
    end
    req_d = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_truth_table();
    int n;
    for (int ab = 0; ab < 4; ab++) begin
      @(negedge clk);
      req_d = 4'b0100; a_d[2] = ab[1]; b_d[2] = ab[0];
      n = 0;
      do begin
        @(negedge clk); n++;
        checks++;
        if (dut_vec !== exp_vec) begin
          errors++;
          $display("FAIL tt_model: got %b expected %b", dut_vec, exp_vec);
        end
      end while (bus.ack == '0 && n < 10);
      checks++;
      if (bus.ack !== 4'b0100 || bus.rsp_id !== 2'd2 || bus.rsp_q !== (ab == 3) || n != 3) begin
        errors++;
        $display("FAIL tt_ab%0d: got ack=%b id=%0d q=%b cycle=%0d expected ack=0100 id=2 q=%b cycle=3",
                 ab, bus.ack, bus.rsp_id, bus.rsp_q, n, (ab == 3));
      end
      req_d = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fairness();
    int order[6] = '{0, 1, 2, 3, 0, 1};
    int got, cyc, last;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    a_d = NREQ'($urandom); b_d = NREQ'($urandom); req_d = '1;
    got = 0; cyc = 0; last = 0;
    while (got < 6 && cyc < 40) begin
      @(negedge clk); cyc++;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL fair_model: got %b expected %b", dut_vec, exp_vec);
      end
      if (bus.ack != '0) begin
        checks++;
        if (bus.ack !== (NREQ'(1) << order[got])) begin
          errors++;
          $display("FAIL fair_order%0d: got ack=%b expected ack=%b", got, bus.ack, NREQ'(1) << order[got]);
        end
        if (got > 0) begin
          checks++;
          if (cyc - last != 3) begin
            errors++;
            $display("FAIL fair_spacing%0d: got %0d cycles expected 3", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
    end
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL fair_count: got %0d acks expected 6", got);
    end
    req_d = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ack_masking();
    int n;
    @(negedge clk);
    req_d = 4'b0010; a_d[1] = 1'b1; b_d[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL mask_model: got %b expected %b", dut_vec, exp_vec);
      end
    end while (bus.ack == '0 && n < 10);
    checks++;
    if (bus.ack !== 4'b0010 || n != 3) begin
      errors++;
      $display("FAIL mask_first_ack: got ack=%b cycle=%0d expected ack=0010 cycle=3", bus.ack, n);
    end
    // Keep req[1] high through the ack cycle and one cycle beyond.
    n = 0;
    do begin
      @(negedge clk); n++;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL mask_model2: got %b expected %b", dut_vec, exp_vec);
      end
      if (n == 2) req_d[1] = 1'b0;
    end while (bus.ack == '0 && n < 10);
    checks++;
    if (bus.ack !== 4'b0010 || n != 4) begin
      errors++;
      $display("FAIL mask_regrant: got ack=%b after %0d cycles expected ack=0010 after 4", bus.ack, n);
    end
    req_d = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    req_d = 4'b1000; a_d[3] = 1'b1; b_d[3] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dbg_state !== CAPTURE || dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL mid_capture: got state=%0d vec=%b expected state=%0d vec=%b", dbg_state, dut_vec, CAPTURE, exp_vec);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL mid_reset: got %b expected %b", dut_vec, {VW{1'b0}});
    end
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL mid_model: got %b expected %b", dut_vec, exp_vec);
      end
    end while (bus.ack == '0 && n < 10);
    checks++;
    if (bus.ack !== 4'b1000 || bus.rsp_q !== 1'b1 || bus.rsp_id !== 2'd3 || n != 3) begin
      errors++;
      $display("FAIL mid_regrant: got ack=%b q=%b id=%0d cycle=%0d expected ack=1000 q=1 id=3 cycle=3",
               bus.ack, bus.rsp_q, bus.rsp_id, n);
    end
    req_d = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int acks0;
    acks0 = model_acks;
    dut_acks = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL rand_model cyc%0d: got %b expected %b", cyc, dut_vec, exp_vec);
      end
      if (bus.ack != '0) dut_acks++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_d[i]) begin
          if (bus.ack[i] && $urandom_range(0, 3) != 0) req_d[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_d[i] = 1'b1;
          a_d[i] = 1'($urandom_range(0, 1));
          b_d[i] = 1'($urandom_range(0, 1));
        end
      end
    end
    checks++;
    if (dut_acks != model_acks - acks0) begin
      errors++;
      $display("FAIL rand_ack_count: got %0d expected %0d", dut_acks, model_acks - acks0);
    end
    req_d = '0;
    repeat (4) @(negedge clk);
  endtask

`ifdef APPLE_SCHED_CHECK_EN
  task automatic test_check_err();
    int n;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    force_en = 1'b1; force_val = 1'b1;
    req_d = 4'b0001; a_d[0] = 1'b1; b_d[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (bus.ack == '0 && n < 10);
    checks++;
    if (bus.err !== 1'b1 || bus.rsp_q !== 1'b1 || n != 3) begin
      errors++;
      $display("FAIL err_set: got err=%b q=%b cycle=%0d expected err=1 q=1 cycle=3", bus.err, bus.rsp_q, n);
    end
    req_d = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky: got %b expected 1", bus.err);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", bus.err);
    end
    rst = 1'b0; force_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`endif

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_d = '0; a_d = '0; b_d = '0;
    force_en = 1'b0; force_val = 1'b0;
    test_reset();
    test_truth_table();
    test_fairness();
    test_ack_masking();
    test_reset_mid();
    test_random();
`ifdef APPLE_SCHED_CHECK_EN
    test_check_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
